rdata_uart_tx: RTL and testbench
================================

// Module: rdata_uart_tx
// PURPOSE
//  Read-response return path: captures each acknowledged Wishbone read (adr, dat) from the core
//  bus mux, buffers it in a small FIFO, and serialises it as 8N1 UART onto RX1 toward the LPC MCU.
//  Sits directly downstream of the DAT/ACK multiplexer.
//  The krake_bus master drives stb/we/adr into it in parallel with the slaves.
// PARAMETERS
//  CLK_DIV   434  clk_i cycles per UART bit (>=2); 434 = 115200 baud at 50 MHz
//  DEPTH     16   FIFO entries; power of two, >=2
//  TAG_EN    1    1: send adr byte then dat byte per entry; 0: send dat byte only
// PORTS
//  clk_i     in   1  system clock (GLA); single clock domain
//  rst_i     in   1  reset, asynchronous, active-high
//  stb_i     in   1  bus strobe from krake_bus
//  we_i      in   1  bus write enable; only reads (we_i=0) are captured
//  adr_i     in   8  bus address
//  ack_i     in   1  muxed slave acknowledge
//  dat_i     in   8  muxed slave read data
//  dout      out  1  UART TX line (RX1); idle high
//  busy      out  1  1 while a frame is in flight or FIFO non-empty
//  overflow  out  1  sticky: a read response was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (async): dout=1, busy=0, overflow=0, FIFO empty, FSM=IDLE, armed=1; an in-flight frame is aborted.
//  Capture: hit = stb_i & ~we_i & ack_i & armed; on hit push {adr_i,dat_i} and clear armed.
//   armed is set again on the first cycle with stb_i=0 (one push per bus cycle even if ack_i is held).
//  Full: a hit with FIFO full and no pop that cycle is dropped; overflow<=1 until reset.
//   A hit with FIFO full and a pop in the same cycle is accepted (count unchanged).
//  Empty: no bypass; a pushed entry is visible to the FSM the cycle after the push.
//  Pointers: log2(DEPTH)-bit wrap naturally; count is log2(DEPTH)+1 bits; full=count==DEPTH.
//  FSM states: IDLE, START, DATA, STOP. The bit timer loads CLK_DIV-1, counts to 0, then advances.
//   IDLE: if FIFO non-empty, pop the entry into the shift register. Load byte = TAG_EN ? adr : dat.
//    Go to START. The pop occurs in this cycle.
//   START: dout=0 for CLK_DIV cycles -> DATA with bit index 0.
//   DATA: dout=byte[idx], LSB first, CLK_DIV cycles each. After idx 7 -> STOP.
//   STOP: dout=1 for CLK_DIV cycles. If TAG_EN and the adr byte was just sent, load dat -> START.
//    Otherwise, if the FIFO is non-empty, pop the next entry -> START (back-to-back frames, no idle gap).
//    Otherwise -> IDLE.
//  Latency: hit at cycle N -> pop in IDLE at N+1 -> dout falls at N+2 (registered output).
//  Frame length: 10*CLK_DIV cycles per byte; 20*CLK_DIV cycles per entry when TAG_EN=1.
//  busy = (state!=IDLE) | ~empty, registered with the state.
//  Write cycles, and reads without ack_i, never push; dout stays unaffected.
// STRUCTURE
//  Shared include (reg_defs.v): UART_START_BIT=1'b0, UART_STOP_BIT=1'b1, UART_DATA_BITS=8.
//  Sub-module: sync_fifo (WIDTH=16, DEPTH); one clock, async reset; push/pop/full/empty/count.
//   Pop data is valid combinationally from the read pointer.
//  Top: capture/arm logic, overflow flag, UART FSM with bit timer and 3-bit index.
// TESTING (CLK_DIV=4, DEPTH=4, TAG_EN=1 unless noted)
//  1 Read adr=0x31 dat=0xA5 with ack for 1 cycle.
//    -> dout low 2 cycles after ack.
//    -> frames 0x31 then 0xA5: bits 0,1000_1100,1 then 0,1010_0101,1.
//    -> 80 cycles total; busy drops after.
//  2 Hold ack_i high 5 cycles within one stb -> exactly one entry sent; write with ack -> nothing sent.
//  3 Issue 6 reads back-to-back while the first frame is in flight.
//    -> the first 5 are sent: 1 popped into the FSM plus 4 buffered.
//    -> the 6th is dropped; overflow=1 and stays 1.
//  4 Push while full in the same cycle the FSM pops -> accepted; the entry count is unchanged and no overflow.
//  5 Assert rst_i mid DATA bit 3 -> dout=1 immediately, busy=0, FIFO empty; the next read transmits cleanly.
//  6 TAG_EN=0, CLK_DIV=2, two reads dat=0x00,0xFF.
//    -> two 20-cycle frames back-to-back, stop bit followed directly by the start bit.

Source files
------------

// File: rtl/rdata_uart_tx_pkg.sv
// Shared types and UART framing constants for the read-response UART return path.
package rdata_uart_tx_pkg;

    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;
    localparam int   UART_DATA_BITS = 8;

    // Transmitter sequencing: one START, eight DATA bits, one STOP per byte.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    // One captured read response as stored in the FIFO.
    typedef struct packed {
        logic [7:0] adr;
        logic [7:0] dat;
    } rd_entry_t;

endpackage

// File: rtl/rdata_uart_tx_sync_fifo.sv
// Single-clock FIFO; read data is presented combinationally from the read pointer.
module rdata_uart_tx_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full       = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Next-pointer and occupancy; a push into a full FIFO is only legal alongside a pop.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        push_ok  = push_i & (~full | pop_i);
        pop_ok   = pop_i & ~empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state registers use <= so every flop samples pre-edge values regardless of statement order.
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/rdata_uart_tx.sv
// Captures acknowledged Wishbone reads, buffers them and sends them as 8N1 UART frames.
module rdata_uart_tx
    import rdata_uart_tx_pkg::*;
#(
    parameter int CLK_DIV = 434,
    parameter int DEPTH   = 16,
    parameter bit TAG_EN  = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       stb_i,
    input  logic       we_i,
    input  logic [7:0] adr_i,
    input  logic       ack_i,
    input  logic [7:0] dat_i,
    output logic       dout,
    output logic       busy,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(CLK_DIV);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(CLK_DIV - 1);

    tx_state_e   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  dat_hold_q, dat_hold_d;
    logic        last_q, last_d;
    logic        armed_q, armed_d;
    logic        overflow_q, overflow_d;
    logic        dout_q, dout_d;
    logic        busy_q, busy_d;

    logic        hit;
    logic        take_entry;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [AW:0] fifo_count;
    rd_entry_t   fifo_wdata;
    rd_entry_t   fifo_rdata;

    rdata_uart_tx_sync_fifo #(
        .WIDTH ($bits(rd_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (fifo_push),
        .push_data_i (fifo_wdata),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_rdata),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign fifo_full = (fifo_count == (AW+1)'(DEPTH));

    // Capture: one push per bus cycle, re-armed once the strobe drops; drops set a sticky flag.
    always_comb begin
        hit        = stb_i & ~we_i & ack_i & armed_q;
        fifo_wdata = '{adr: adr_i, dat: dat_i};
        fifo_push  = hit & (~fifo_full | fifo_pop);
        overflow_d = overflow_q | (hit & fifo_full & ~fifo_pop);
        armed_d    = armed_q;
        if (hit)         armed_d = 1'b0;
        else if (!stb_i) armed_d = 1'b1;
    end

    // UART sequencer: bit timer, bit index, entry pop and registered line/busy values.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        dat_hold_d = dat_hold_q;
        last_d     = last_q;
        take_entry = 1'b0;
        fifo_pop   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) take_entry = 1'b1;
            end
            ST_START: begin
                if (timer_q == '0) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                    timer_d = TIMER_LOAD;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_DATA: begin
                if (timer_q == '0) begin
                    timer_d = TIMER_LOAD;
                    if (idx_q == 3'(UART_DATA_BITS - 1)) state_d = ST_STOP;
                    else                                  idx_d   = idx_q + 3'd1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_STOP: begin
                if (timer_q == '0) begin
                    if (!last_q) begin
                        // Address byte just went out; follow with the held data byte.
                        shreg_d = dat_hold_q;
                        last_d  = 1'b1;
                        state_d = ST_START;
                        timer_d = TIMER_LOAD;
                    end else if (!fifo_empty) begin
                        take_entry = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (take_entry) begin
            fifo_pop   = 1'b1;
            shreg_d    = TAG_EN ? fifo_rdata.adr : fifo_rdata.dat;
            dat_hold_d = fifo_rdata.dat;
            last_d     = (TAG_EN == 1'b0);
            state_d    = ST_START;
            timer_d    = TIMER_LOAD;
        end

        case (state_d)
            ST_START: dout_d = UART_START_BIT;
            ST_DATA:  dout_d = shreg_d[idx_d];
            default:  dout_d = UART_STOP_BIT;
        endcase

        // A pop always lands in START, so without a pop the FIFO is non-empty next cycle
        // exactly when it is non-empty now or is being pushed.
        busy_d = (state_d != ST_IDLE) | ~fifo_empty | fifo_push;
    end

    // State registers; reset aborts any frame in flight and returns the line to idle-high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            dat_hold_q <= '0;
            last_q     <= 1'b0;
            armed_q    <= 1'b1;
            overflow_q <= 1'b0;
            dout_q     <= UART_STOP_BIT;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            dat_hold_q <= dat_hold_d;
            last_q     <= last_d;
            armed_q    <= armed_d;
            overflow_q <= overflow_d;
            dout_q     <= dout_d;
            busy_q     <= busy_d;
        end
    end

    assign dout     = dout_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_rdata_uart_tx.sv
// Directed bench for rdata_uart_tx: u_dut1 (CLK_DIV=4, DEPTH=4, TAG_EN=1), u_dut2 (CLK_DIV=2, TAG_EN=0).
module tb_rdata_uart_tx;

    logic       clk;
    logic       rst1, stb1, we1, ack1, dout1, busy1, ovf1;
    logic [7:0] adr1, dat1;
    logic       rst2, stb2, we2, ack2, dout2, busy2, ovf2;
    logic [7:0] adr2, dat2;

    int n_vec;
    int n_fail;

    logic [7:0] t3_adr [6];
    logic [7:0] t3_dat [6];
    logic [7:0] t4_adr [6];
    logic [7:0] t4_dat [6];

    rdata_uart_tx #(.CLK_DIV(4), .DEPTH(4), .TAG_EN(1'b1)) u_dut1 (
        .clk_i(clk), .rst_i(rst1), .stb_i(stb1), .we_i(we1), .adr_i(adr1),
        .ack_i(ack1), .dat_i(dat1), .dout(dout1), .busy(busy1), .overflow(ovf1)
    );

    rdata_uart_tx #(.CLK_DIV(2), .DEPTH(4), .TAG_EN(1'b0)) u_dut2 (
        .clk_i(clk), .rst_i(rst2), .stb_i(stb2), .we_i(we2), .adr_i(adr2),
        .ack_i(ack2), .dat_i(dat2), .dout(dout2), .busy(busy2), .overflow(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic line_of(input bit sel);
        return sel ? dout2 : dout1;
    endfunction

    function automatic logic busy_of(input bit sel);
        return sel ? busy2 : busy1;
    endfunction

    // One-cycle acknowledged read followed by one idle cycle (re-arms capture).
    task automatic read1(input logic [7:0] a, input logic [7:0] d);
        stb1 = 1'b1; we1 = 1'b0; adr1 = a; dat1 = d; ack1 = 1'b1;
        @(negedge clk);
        stb1 = 1'b0; ack1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic read2(input logic [7:0] a, input logic [7:0] d);
        stb2 = 1'b1; we2 = 1'b0; adr2 = a; dat2 = d; ack2 = 1'b1;
        @(negedge clk);
        stb2 = 1'b0; ack2 = 1'b0;
        @(negedge clk);
    endtask

    // Waits (bounded) for a start bit, then samples each bit once per bit period.
    // waited = negedges elapsed until the start bit was first seen.
    task automatic rx_frame(input bit sel, input int d, output logic [7:0] b, output int waited);
        waited = 0;
        b = 'x;
        do begin
            @(negedge clk);
            waited++;
        end while (line_of(sel) !== 1'b0 && waited < 200);
        if (line_of(sel) !== 1'b0) begin
            check("rx_start_timeout", {31'd0, line_of(sel)}, 32'd0);
            return;
        end
        for (int i = 0; i < 8; i++) begin
            repeat (d) @(negedge clk);
            b[i] = line_of(sel);
        end
        repeat (d) @(negedge clk);
        check("rx_stop_bit", {31'd0, line_of(sel)}, 32'd1);
    endtask

    // Address frame then data frame of one tagged entry.
    task automatic rx_entry(input bit sel, input int d, input logic [7:0] a, input logic [7:0] v,
                            input int first_wait);
        logic [7:0] b;
        int w;
        rx_frame(sel, d, b, w);
        check("entry_gap", w, first_wait);
        check("entry_adr", {24'd0, b}, {24'd0, a});
        rx_frame(sel, d, b, w);
        check("tag_gap", w, d);
        check("entry_dat", {24'd0, b}, {24'd0, v});
    endtask

    // After the last stop-bit sample: busy stays up to the end of the stop bit, then drops.
    task automatic rx_tail(input bit sel, input int d);
        repeat (d - 1) @(negedge clk);
        check("busy_in_stop", {31'd0, busy_of(sel)}, 32'd1);
        @(negedge clk);
        check("busy_after", {31'd0, busy_of(sel)}, 32'd0);
        check("line_idle", {31'd0, line_of(sel)}, 32'd1);
    endtask

    initial begin
        int lows;
        int highs;
        logic [7:0] b;
        int w;

        n_vec = 0;
        n_fail = 0;
        t3_adr = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
        t3_dat = '{8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A};
        t4_adr = '{8'h81, 8'h92, 8'hA3, 8'hB4, 8'hC5, 8'hD6};
        t4_dat = '{8'h18, 8'h29, 8'h3A, 8'h4B, 8'h5C, 8'h6D};
        {stb1, we1, ack1, adr1, dat1} = '0;
        {stb2, we2, ack2, adr2, dat2} = '0;
        rst1 = 1'b1;
        rst2 = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_dout", {31'd0, dout1}, 32'd1);
        check("rst_busy", {31'd0, busy1}, 32'd0);
        check("rst_ovf", {31'd0, ovf1}, 32'd0);
        check("rst_dout2", {31'd0, dout2}, 32'd1);
        rst1 = 1'b0;
        rst2 = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_dout", {31'd0, dout1}, 32'd1);
        check("idle_busy", {31'd0, busy1}, 32'd0);

        // 1: single read, 0x31 then 0xA5, dout low two cycles after the ack cycle, 80 cycles.
        stb1 = 1'b1; we1 = 1'b0; adr1 = 8'h31; dat1 = 8'hA5; ack1 = 1'b1;
        @(negedge clk);
        check("t1_no_bypass", {31'd0, dout1}, 32'd1);
        check("t1_busy_on_push", {31'd0, busy1}, 32'd1);
        stb1 = 1'b0; ack1 = 1'b0;
        rx_entry(1'b0, 4, 8'h31, 8'hA5, 1);
        rx_tail(1'b0, 4);

        // 2: ack held 5 cycles in one strobe -> one entry; write and ack-less read -> nothing.
        fork
            begin
                stb1 = 1'b1; we1 = 1'b0; adr1 = 8'h52; dat1 = 8'h3C; ack1 = 1'b1;
                repeat (5) @(negedge clk);
                ack1 = 1'b0;
                @(negedge clk);
                stb1 = 1'b0;
            end
            rx_entry(1'b0, 4, 8'h52, 8'h3C, 2);
        join
        rx_tail(1'b0, 4);
        stb1 = 1'b1; we1 = 1'b1; adr1 = 8'h66; dat1 = 8'h00; ack1 = 1'b1;
        repeat (2) @(negedge clk);
        stb1 = 1'b0; ack1 = 1'b0;
        @(negedge clk);
        stb1 = 1'b1; we1 = 1'b0; adr1 = 8'h77;
        repeat (2) @(negedge clk);
        stb1 = 1'b0;
        lows = 0;
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dout1 !== 1'b1) lows++;
            if (busy1 !== 1'b0) highs++;
        end
        check("t2_write_line", lows, 0);
        check("t2_write_busy", highs, 0);

        // 3: six reads while the first frame is in flight -> five sent, sixth dropped.
        fork
            begin
                for (int i = 0; i < 5; i++) read1(t3_adr[i], t3_dat[i]);
                check("t3_ovf_before", {31'd0, ovf1}, 32'd0);
                read1(t3_adr[5], t3_dat[5]);
                check("t3_ovf_set", {31'd0, ovf1}, 32'd1);
            end
            begin
                for (int i = 0; i < 5; i++) rx_entry(1'b0, 4, t3_adr[i], t3_dat[i], (i == 0) ? 2 : 4);
            end
        join
        rx_tail(1'b0, 4);
        check("t3_ovf_sticky", {31'd0, ovf1}, 32'd1);

        // 5: reset in the middle of data bit 3 of the address byte (0x31 bit3 = 0).
        stb1 = 1'b1; we1 = 1'b0; adr1 = 8'h31; dat1 = 8'h77; ack1 = 1'b1;
        @(negedge clk);
        stb1 = 1'b0; ack1 = 1'b0;
        repeat (17) @(negedge clk);
        check("t5_bit3_low", {31'd0, dout1}, 32'd0);
        #2 rst1 = 1'b1;
        #1;
        check("t5_rst_dout", {31'd0, dout1}, 32'd1);
        check("t5_rst_busy", {31'd0, busy1}, 32'd0);
        check("t5_rst_ovf", {31'd0, ovf1}, 32'd0);
        @(negedge clk);
        rst1 = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_empty_busy", {31'd0, busy1}, 32'd0);
        check("t5_empty_line", {31'd0, dout1}, 32'd1);
        stb1 = 1'b1; we1 = 1'b0; adr1 = 8'hE4; dat1 = 8'h96; ack1 = 1'b1;
        @(negedge clk);
        stb1 = 1'b0; ack1 = 1'b0;
        rx_entry(1'b0, 4, 8'hE4, 8'h96, 1);
        rx_tail(1'b0, 4);

        // 4: FIFO full; the next read lands exactly on the pop cycle (hit 81 cycles after the first).
        fork
            begin
                for (int i = 0; i < 5; i++) read1(t4_adr[i], t4_dat[i]);
                repeat (71) @(negedge clk);
                read1(t4_adr[5], t4_dat[5]);
                check("t4_ovf_clear", {31'd0, ovf1}, 32'd0);
            end
            begin
                for (int i = 0; i < 6; i++) rx_entry(1'b0, 4, t4_adr[i], t4_dat[i], (i == 0) ? 2 : 4);
            end
        join
        rx_tail(1'b0, 4);
        check("t4_ovf_final", {31'd0, ovf1}, 32'd0);

        // 6: TAG_EN=0, CLK_DIV=2: 0x00 and 0xFF as back-to-back 20-cycle frames.
        fork
            begin
                read2(8'h11, 8'h00);
                read2(8'h22, 8'hFF);
            end
            begin
                rx_frame(1'b1, 2, b, w);
                check("t6_gap0", w, 2);
                check("t6_byte0", {24'd0, b}, 32'h00);
                rx_frame(1'b1, 2, b, w);
                check("t6_gap1", w, 2);
                check("t6_byte1", {24'd0, b}, 32'hFF);
            end
        join
        rx_tail(1'b1, 2);
        check("t6_ovf", {31'd0, ovf2}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
